// File: rtl/pp_row_accumulator.sv
// Multi-cycle shift-and-add consumer of partial-product rows: one row per
// handshake, WIDTH rows per 2*WIDTH-bit product, optional low-column truncation.
module pp_row_accumulator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TRUNC = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           row_data,
    input  logic                       flush,
    output logic [$clog2(WIDTH)-1:0]   row_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH-1:0]         product
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;
    // Clears the TRUNC low product columns of every shifted row.
    localparam logic [PW-1:0] TRUNC_MASK = ~((PW'(1) << TRUNC) - PW'(1));

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_d;
    logic [IW-1:0]   idx_d;
    logic [PW-1:0]   product_d;
    logic            out_valid_d;
    logic            accept;
    logic            last_row;
    logic [PW-1:0]   term;
    logic [PW-1:0]   sum;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            acc       <= '0;
            row_idx   <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            row_idx   <= idx_d;
            product   <= product_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state, row acceptance and accumulation.
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        idx_d       = row_idx;
        product_d   = product;
        out_valid_d = 1'b0;

        in_ready = !rst && (state == COLLECT);
        accept   = in_valid && in_ready;
        last_row = (row_idx == IW'(WIDTH - 1));
        term     = ({{WIDTH{1'b0}}, row_data} << row_idx) & TRUNC_MASK;
        // Row 0 restarts from zero, so stale content never needs a clear cycle.
        sum      = ((row_idx == '0) ? '0 : acc) + term;

        case (state)
            COLLECT: begin
                if (flush) begin
                    acc_d = '0;
                    idx_d = '0;
                end else if (accept) begin
                    acc_d = sum;
                    if (last_row) begin
                        idx_d       = '0;
                        product_d   = sum;
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                    end else begin
                        idx_d = row_idx + IW'(1);
                    end
                end
            end
            HOLD: begin
                out_valid_d = 1'b1;
                // A flush discards the pending product exactly like a handshake
                // would release it; product itself is left untouched.
                if (flush || out_ready) begin
                    state_d     = COLLECT;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

endmodule

// File: tb/tb_pp_row_accumulator.sv
// Randomized bench for pp_row_accumulator: exact and TRUNC=8 instances share
// stimulus and are compared against a bit-serial multiply reference.
module tb_pp_row_accumulator;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  row_data;
    logic          flush;
    logic          out_ready;

    logic          in_ready0, in_ready8;
    logic [3:0]    row_idx0, row_idx8;
    logic          out_valid0, out_valid8;
    logic [31:0]   product0, product8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pp_row_accumulator #(.WIDTH(W), .TRUNC(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .row_data(row_data), .flush(flush), .row_idx(row_idx0),
        .out_valid(out_valid0), .out_ready(out_ready), .product(product0)
    );

    pp_row_accumulator #(.WIDTH(W), .TRUNC(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .row_data(row_data), .flush(flush), .row_idx(row_idx8),
        .out_valid(out_valid8), .out_ready(out_ready), .product(product8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: sum of x[k]*y*2^k with each row's low trunc columns dropped.
    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                             input int trunc);
        logic [63:0] s;
        logic [63:0] t;
        s = 64'd0;
        for (int k = 0; k < 16; k++) begin
            if (x[k]) begin
                t = 64'(y) << k;
                t = (t >> trunc) << trunc;
                s = s + t;
            end
        end
        return s[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rows(input logic [15:0] x, input logic [15:0] y, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            row_data = x[k] ? y : 16'h0;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy0"}, 64'(in_ready0), 64'd1);
        check({tag, "_rdy8"}, 64'(in_ready8), 64'd1);
        check({tag, "_ov0"}, 64'(out_valid0), 64'd0);
        check({tag, "_ov8"}, 64'(out_valid8), 64'd0);
        check({tag, "_idx0"}, 64'(row_idx0), 64'd0);
    endtask

    task automatic run_frame(input logic [15:0] x, input logic [15:0] y, input int gap_pct,
                             input int hold, input bit flush_in_hold);
        logic [31:0] e0;
        logic [31:0] e8;
        e0 = ref_prod(x, y, 0);
        e8 = ref_prod(x, y, 8);
        out_ready = (hold == 0) && !flush_in_hold;
        for (int k = 0; k < 16; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                row_data = 16'($urandom);
                check("gap_rdy", 64'(in_ready0), 64'd1);
                check("gap_idx", 64'(row_idx0), 64'(k));
                step();
            end
            in_valid = 1'b1;
            row_data = x[k] ? y : 16'h0;
            check("row_idx0", 64'(row_idx0), 64'(k));
            check("row_idx8", 64'(row_idx8), 64'(k));
            check("row_rdy", 64'(in_ready0), 64'd1);
            step();
        end
        in_valid = 1'b0;
        check("done_ov0", 64'(out_valid0), 64'd1);
        check("done_ov8", 64'(out_valid8), 64'd1);
        check("done_prod0", 64'(product0), 64'(e0));
        check("done_prod8", 64'(product8), 64'(e8));
        check("done_idx", 64'(row_idx0), 64'd0);
        check("done_rdy", 64'(in_ready0), 64'd0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            row_data  = 16'($urandom);
            step();
            check("hold_ov", 64'(out_valid0), 64'd1);
            check("hold_rdy", 64'(in_ready0), 64'd0);
            check("hold_prod0", 64'(product0), 64'(e0));
            check("hold_prod8", 64'(product8), 64'(e8));
            check("hold_idx", 64'(row_idx0), 64'd0);
        end
        in_valid = 1'b0;
        if (flush_in_hold) begin
            flush     = 1'b1;
            out_ready = 1'b1;
            check("pre_flush_ov", 64'(out_valid0), 64'd1);
        end else begin
            out_ready = 1'b1;
        end
        step();
        flush     = 1'b0;
        out_ready = 1'b0;
        check_idle("release");
        check("kept_prod0", 64'(product0), 64'(e0));
        check("kept_prod8", 64'(product8), 64'(e8));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        row_data  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        check("rst_rdy0", 64'(in_ready0), 64'd0);
        check("rst_rdy8", 64'(in_ready8), 64'd0);
        check("rst_prod", 64'(product0), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check_idle("post_rst");

        // 3 x 5, no gaps, out_ready held high.
        run_frame(16'h0003, 16'h0005, 0, 0, 1'b0);
        check("p_3x5", 64'(product0), 64'h0000000F);

        // All-ones with gaps, exact and truncated.
        run_frame(16'hFFFF, 16'hFFFF, 40, 0, 1'b0);
        check("p_ff_exact", 64'(product0), 64'hFFFE0001);
        check("p_ff_trunc", 64'(product8), 64'hFFFDF900);

        // Backpressure with rows offered during HOLD.
        run_frame(16'hA5C3, 16'h7E19, 20, 10, 1'b0);

        // Flush mid-frame at row 7 together with a valid row.
        drive_rows(16'hBEEF, 16'hCAFE, 7);
        check("pre_flush_idx", 64'(row_idx0), 64'd7);
        in_valid = 1'b1;
        row_data = 16'hCAFE;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idx0", 64'(row_idx0), 64'd0);
        check("flush_idx8", 64'(row_idx8), 64'd0);
        check("flush_ov", 64'(out_valid0), 64'd0);
        run_frame(16'h1234, 16'h0100, 10, 0, 1'b0);
        check("p_1234", 64'(product0), 64'h00123400);

        // Flush while holding a product.
        run_frame(16'h00FF, 16'h0F0F, 0, 2, 1'b1);

        // Reset at row 9, then in HOLD.
        drive_rows(16'hFFFF, 16'h1357, 9);
        check("pre_rst_idx", 64'(row_idx0), 64'd9);
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        check("rst_mid_rdy", 64'(in_ready0), 64'd0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle("rst_mid");
        check("rst_mid_prod0", 64'(product0), 64'd0);
        check("rst_mid_prod8", 64'(product8), 64'd0);

        out_ready = 1'b0;
        drive_rows(16'h7777, 16'h9999, 16);
        check("pre_rst_hold_ov", 64'(out_valid0), 64'd1);
        check("pre_rst_hold_prod", 64'(product0), 64'(ref_prod(16'h7777, 16'h9999, 0)));
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        check_idle("rst_hold");
        check("rst_hold_prod0", 64'(product0), 64'd0);
        check("rst_hold_prod8", 64'(product8), 64'd0);

        run_frame(16'h8000, 16'h8000, 0, 0, 1'b0);
        check("p_8000", 64'(product0), 64'h40000000);
        check("p_8000_t", 64'(product8), 64'h40000000);

        // Randomized frames, gaps and hold times.
        for (int f = 0; f < 40; f++) begin
            run_frame(16'($urandom), 16'($urandom), int'($urandom_range(50)),
                      int'($urandom_range(4)), 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pp_row_accumulator.md
Name: pp_row_accumulator

Overview:
Sequential consumer of partial-product rows: accepts the WIDTH rows of a WIDTH x WIDTH unsigned multiply one per handshake (row k = x[k] ? y : 0), shifts each row by its index, and accumulates to a 2*WIDTH product.
Sits downstream of the combinational partial-product generator. It is the low-area, multi-cycle alternative to the compressor tree.
Optional low-column truncation (TRUNC) gives an approximate-product mode matching the team's approximate multiplier work.

Parameters:
WIDTH, 16, operand width; also number of rows per product.
TRUNC, 0, number of low product columns discarded from every row before accumulation (0 = exact; legal range 0..2*WIDTH-1).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  row_data valid.
in_ready  output  1  block can accept a row this cycle.
row_data  input  WIDTH  current partial-product row; unshifted, LSB aligned.
flush  input  1  synchronous abort of the current frame.
row_idx  output  log2(WIDTH) (4 at default)  index of the next row to be accepted.
out_valid  output  1  product valid.
out_ready  input  1  downstream accepts product.
product  output  2*WIDTH  accumulated product.

Behaviour:
- Reset values: in_ready=0 during the rst cycle, then 1. row_idx=0, out_valid=0, product=0, accumulator=0, state=COLLECT.
- States: COLLECT and HOLD.
- COLLECT:
  - in_ready=1, out_valid=0.
  - Accept condition: in_valid & in_ready.
  - On accept: term = ({WIDTH'b0,row_data} << row_idx) with bits [TRUNC-1:0] forced to 0.
  - acc <= (row_idx==0 ? 0 : acc) + term, evaluated mod 2^(2*WIDTH).
  - row_idx increments on each accept.
  - Row 0 implicitly clears stale accumulator content, so no separate clear cycle is needed.
- Last row (accept with row_idx==WIDTH-1):
  - product <= acc + term.
  - row_idx wraps to 0.
  - Next state HOLD; out_valid=1 on the following cycle.
  - Latency: product is valid 1 cycle after the last row is accepted.
- HOLD:
  - in_ready=0, out_valid=1.
  - product is stable until the out_valid & out_ready handshake.
  - On handshake: next cycle out_valid=0, state=COLLECT, in_ready=1.
  - No bypass. A row presented in the handshake cycle is not accepted (in_ready=0). Minimum frame period is WIDTH+1 cycles.
- No overflow is possible: the sum of exact rows is at most (2^WIDTH-1)^2.
- in_valid low in COLLECT: acc and row_idx are held (gaps allowed mid-frame).
- flush:
  - In COLLECT: row_idx <= 0, acc <= 0. Flush has priority over a simultaneous in_valid; that row is dropped.
  - In HOLD: out_valid <= 0, state <= COLLECT, product retains its value. Flush has priority over a simultaneous out_ready; the pending product is discarded.
- rst has priority over flush and over every handshake. Reset mid-frame or in HOLD returns all state to reset values and discards the partial result.
- product only changes on the last-row accept or on rst.
- row_idx is a registered output and always reflects the next index to be consumed.

Test Plan:
- x=3, y=5, rows driven as generated (rows 0,1 = 5, rows 2..15 = 0), in_valid held high, out_ready=1 -> out_valid high exactly 1 cycle after row 15 is accepted, product=0x0000000F, row_idx=0.
- x=y=0xFFFF, TRUNC=0, random in_valid gaps -> product=0xFFFE0001. in_ready stays 1 during gaps, row_idx advances only on accepts.
- Same x=y=0xFFFF stimulus, TRUNC=8 -> product=0xFFFDF900 (exact product minus 0x701 of discarded low-column bits).
- Backpressure: out_ready=0 for 10 cycles after completion -> product held constant, in_ready=0, rows offered meanwhile are not consumed. out_ready=1 -> out_valid drops next cycle, in_ready=1.
- flush asserted with in_valid at row_idx=7 -> that row is dropped, row_idx=0. A following full frame for x=0x1234, y=0x0100 gives product=0x00123400. flush in HOLD -> out_valid=0 next cycle, no handshake occurs.
- rst asserted at row_idx=9 and again in HOLD -> next cycle all outputs at reset values. A subsequent frame for x=0x8000, y=0x8000 gives product=0x40000000.
